cla_seq_adder: RTL and testbench

Multi-cycle W-bit adder that streams wide operands through a single 4-bit carry-lookahead slice, one nibble per cycle, least-significant nibble first. The carry from each nibble is registered and fed into the next. The block sits directly upstream of the 4-bit CLA datapath: it owns the operand sequencing, the carry chaining and the valid/ready handshakes. It lets wide additions reuse one small lookahead slice instead of a full-width adder.

---
 rtl/cla_seq_adder_if.sv | 26 ++
 rtl/cla_seq_adder.sv | 101 ++++++++++
 tb/tb_cla_seq_adder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle for cla_seq_adder: operands with valid/ready in,
// result with valid/ready out. WIDTH must match the adder instance it connects to.
interface cla_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_seq_adder.sv
// Wide adder streaming operands one nibble per cycle through a single 4-bit CLA slice.
// Latency: result valid WIDTH/4 edges after accept; throughput one result per WIDTH/4+1 cycles.
// Backpressure: result held in DONE until out_ready; new operands accepted on the consuming edge.
module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           rst_n,
    cla_seq_adder_if.slave bus
);
    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  sum_q;
    logic              carry;
    logic              cout_q;
    logic              ovf_q;
    logic [IDXW-1:0]   idx;
    logic              ready_c;
    logic              valid_c;
    logic              accept;

    logic [3:0] na, nb, p, g, s;
    logic       c1, c2, c3, c4;

    // 4-bit lookahead slice on the current nibble
    always_comb begin
        na = op_a[{idx, 2'b00} +: 4];
        nb = op_b[{idx, 2'b00} +: 4];
        p  = na ^ nb;
        g  = na & nb;
        c1 = g[0] | (p[0] & carry);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & carry);
        s  = p ^ {c3, c2, c1, carry};
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        valid_c   = 1'b0;
        case (state)
            IDLE: ready_c = rst_n;
            CALC: if (idx == LAST) state_nxt = DONE;
            DONE: begin
                valid_c = 1'b1;
                ready_c = rst_n & bus.out_ready;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        accept = bus.in_valid & ready_c;
        if (accept) state_nxt = CALC;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
        end else if (state == CALC) begin
            sum_q[{idx, 2'b00} +: 4] <= s;
            carry <= c4;
            if (idx == LAST) begin
                cout_q <= c4;
                ovf_q  <= c3 ^ c4;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = valid_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: WIDTH=16 and WIDTH=8 instances, hand-computed vectors,
// latency, backpressure, back-to-back streaming and mid-operation reset.
module tb_cla_seq_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   lat;
    int   cyc;
    int   seen;

    cla_seq_adder_if #(.WIDTH(16)) bus16 ();
    cla_seq_adder_if #(.WIDTH(8))  bus8 ();

    cla_seq_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    cla_seq_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    always #5 clk = ~clk;

    logic [15:0] ta [3] = '{16'h0001, 16'h00F0, 16'hFFFF};
    logic [15:0] tb [3] = '{16'h0002, 16'h0F0F, 16'hFFFF};
    logic        tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] es [3] = '{16'h0003, 16'h0FFF, 16'hFFFF};
    logic        ec [3] = '{1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait16(output int l);
        l = 0;
        while (bus16.out_valid !== 1'b1 && l < 12) begin
            tick();
            l++;
        end
    endtask

    task automatic add16(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] exp_s, input logic exp_c, input logic exp_o,
                         input string tag);
        int l;
        bus16.a = a;
        bus16.b = b;
        bus16.cin = c;
        bus16.in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(bus16.in_ready), 32'd1);
        tick();
        bus16.in_valid = 1'b0;
        wait16(l);
        chk({tag, "_latency"}, 32'(l), 32'd4);
        chk({tag, "_sum"}, 32'(bus16.sum), 32'(exp_s));
        chk({tag, "_cout"}, 32'(bus16.cout), 32'(exp_c));
        chk({tag, "_ovf"}, 32'(bus16.ovf), 32'(exp_o));
        tick();
        chk({tag, "_consumed"}, 32'(bus16.out_valid), 32'd0);
    endtask

    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] exp_s, input logic exp_c, input logic exp_o,
                        input string tag);
        int l;
        bus8.a = a;
        bus8.b = b;
        bus8.cin = c;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        l = 0;
        while (bus8.out_valid !== 1'b1 && l < 12) begin
            tick();
            l++;
        end
        chk({tag, "_latency"}, 32'(l), 32'd2);
        chk({tag, "_sum"}, 32'(bus8.sum), 32'(exp_s));
        chk({tag, "_cout"}, 32'(bus8.cout), 32'(exp_c));
        chk({tag, "_ovf"}, 32'(bus8.ovf), 32'(exp_o));
        tick();
        chk({tag, "_consumed"}, 32'(bus8.out_valid), 32'd0);
    endtask

    initial begin
        bus16.in_valid = 1'b0;
        bus16.a = '0;
        bus16.b = '0;
        bus16.cin = 1'b0;
        bus16.out_ready = 1'b1;
        bus8.in_valid = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus8.cin = 1'b0;
        bus8.out_ready = 1'b1;

        tick();
        tick();
        chk("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus16.in_ready), 32'd0);
        chk("rst_sum", 32'(bus16.sum), 32'd0);
        chk("rst_cout", 32'(bus16.cout), 32'd0);
        chk("rst_ovf", 32'(bus16.ovf), 32'd0);
        chk("rst8_out_valid", 32'(bus8.out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(bus16.in_ready), 32'd1);

        add16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
        add16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "sovf");
        add16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "cin");
        add16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "negovf");

        // backpressure: result must hold while in_valid pulses are ignored
        bus16.out_ready = 1'b0;
        bus16.a = 16'h00FF;
        bus16.b = 16'h0F01;
        bus16.cin = 1'b0;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        wait16(lat);
        chk("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            bus16.in_valid = i[0];
            bus16.a = 16'h1111;
            bus16.b = 16'h1111;
            tick();
            chk("bp_out_valid", 32'(bus16.out_valid), 32'd1);
            chk("bp_sum", 32'(bus16.sum), 32'h1000);
            chk("bp_in_ready", 32'(bus16.in_ready), 32'd0);
        end
        chk("bp_cout", 32'(bus16.cout), 32'd0);
        chk("bp_ovf", 32'(bus16.ovf), 32'd0);
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        tick();
        chk("bp_consumed", 32'(bus16.out_valid), 32'd0);
        chk("bp_idle_ready", 32'(bus16.in_ready), 32'd1);

        // back-to-back with in_valid held high
        bus16.a = ta[0];
        bus16.b = tb[0];
        bus16.cin = tc[0];
        bus16.in_valid = 1'b1;
        tick();
        bus16.a = ta[1];
        bus16.b = tb[1];
        bus16.cin = tc[1];
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            while (bus16.in_ready !== 1'b1 && cyc < 20) begin
                tick();
                cyc++;
            end
            chk("b2b_gap", 32'(cyc), 32'd4);
            chk("b2b_out_valid", 32'(bus16.out_valid), 32'd1);
            chk("b2b_sum", 32'(bus16.sum), 32'(es[k]));
            chk("b2b_cout", 32'(bus16.cout), 32'(ec[k]));
            if (k == 2) bus16.in_valid = 1'b0;
            tick();
            if (k < 2) chk("b2b_reaccept", 32'(bus16.in_ready), 32'd0);
            if (k == 0) begin
                bus16.a = ta[2];
                bus16.b = tb[2];
                bus16.cin = tc[2];
            end
        end
        chk("b2b_drained", 32'(bus16.out_valid), 32'd0);
        chk("b2b_idle_ready", 32'(bus16.in_ready), 32'd1);

        // reset two cycles into a calculation
        bus16.a = 16'hAAAA;
        bus16.b = 16'h5555;
        bus16.cin = 1'b0;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("mid_rst_sum", 32'(bus16.sum), 32'd0);
        chk("mid_rst_in_ready_low", 32'(bus16.in_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_in_ready", 32'(bus16.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus16.out_valid === 1'b1) seen++;
        end
        chk("mid_rst_no_result", 32'(seen), 32'd0);
        add16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "fresh");

        add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "w8_neg");
        add8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "w8_pos");
        add8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "w8_nib");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
